// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates instruction fetches and loads/stores onto one single-port memory.
// Define MEM_ARB_STARVE_EN to compile in the fetch wait counter and starvation promotion.
module mem_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {NONE, FETCH, LOAD} rsel_t;
    rsel_t r_rsel, w_rsel_nxt;
    logic  w_promote;
`ifdef MEM_ARB_STARVE_EN
    localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    logic [CW-1:0] r_wait;
    assign w_promote = (r_wait == CW'(MAX_WAIT));
    // counts consecutive lost arbitrations of a pending fetch, saturating
    always_ff @(posedge clk) begin
        if (reset || !i_req || i_gnt) r_wait <= '0;
        else if (!w_promote) r_wait <= r_wait + 1'b1;
    end
`else
    logic w_unused_max_wait;
    assign w_promote         = 1'b0;
    assign w_unused_max_wait = (MAX_WAIT > 0);
`endif
    assign i_gnt     = ~reset & i_req & (w_promote | ~d_req);
    assign d_gnt     = ~reset & d_req & ~i_gnt;
    assign mem_en    = i_gnt | d_gnt;
    assign mem_we    = d_gnt & d_we;
    assign mem_addr  = i_gnt ? i_addr : (d_gnt ? d_addr : '0);
    assign mem_wdata = d_gnt ? d_wdata : '0;
    assign rdata     = mem_rdata;
    assign i_rvalid  = (r_rsel == FETCH);
    assign d_rvalid  = (r_rsel == LOAD);
    always_comb begin
        w_rsel_nxt = i_gnt ? FETCH : ((d_gnt && !d_we) ? LOAD : NONE);
    end
    always_ff @(posedge clk) begin
        r_rsel <= reset ? NONE : w_rsel_nxt;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter against a cycle-level behavioural model.
module tb_mem_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int MW = 3;
    localparam int VW = 4 + AW + DW + 2 + DW;

    logic          clk = 1'b0, reset = 1'b1;
    logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0] i_addr = '0, d_addr = '0;
    logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
    logic          i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
    logic [DW-1:0] rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [1024];
    logic [DW-1:0] ref_mem [1024];

    // memory environment driven by the DUT's memory port
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else mem_rdata <= mem[mem_addr];
        end
    end

    int            n_checks = 0, n_err = 0;
    int            m_wait = 0, m_rsel = 0;
    logic [DW-1:0] m_rd = '0;
    logic          e_ig, e_dg;
    logic [VW-1:0] exp_v;

    function automatic logic [VW-1:0] act_v();
        return {i_gnt, d_gnt, mem_en, mem_we, mem_addr, mem_wdata, i_rvalid, d_rvalid,
                (i_rvalid | d_rvalid) ? rdata : DW'(0)};
    endfunction

    task automatic drive(input logic r, input logic ir, input logic [AW-1:0] ia,
                         input logic dr, input logic dw, input logic [AW-1:0] da,
                         input logic [DW-1:0] wd);
        reset = r; i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = wd;
        @(negedge clk);
        if (r) begin
            e_ig = 1'b0;
            e_dg = 1'b0;
        end else begin
`ifdef MEM_ARB_STARVE_EN
            e_ig = ir && (m_wait >= MW || !dr);
`else
            e_ig = ir && !dr;
`endif
            e_dg = dr && !e_ig;
        end
        exp_v = {e_ig, e_dg, e_ig | e_dg, e_dg & dw,
                 e_ig ? ia : (e_dg ? da : AW'(0)), e_dg ? wd : DW'(0),
                 m_rsel == 1, m_rsel == 2, (m_rsel != 0) ? m_rd : DW'(0)};
    endtask

    task automatic advance();
        @(posedge clk);
        m_wait = (reset || !i_req || e_ig) ? 0 : ((m_wait < MW) ? m_wait + 1 : MW);
        m_rsel = e_ig ? 1 : ((e_dg && !d_we) ? 2 : 0);
        m_rd   = ref_mem[e_ig ? i_addr : d_addr];
        if (e_dg && d_we) ref_mem[d_addr] = d_wdata;
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, AW'(k), 1'b1, 1'b0, AW'(k + 1), '0);
            n_checks++;
            if ({i_gnt, d_gnt, mem_en, mem_we, i_rvalid, d_rvalid} !== 6'b0) begin
                n_err++;
                $display("FAIL reset_quiet cyc=%0d got=%b exp=000000", k,
                         {i_gnt, d_gnt, mem_en, mem_we, i_rvalid, d_rvalid});
            end
            n_checks++;
            if (act_v() !== exp_v) begin
                n_err++;
                $display("FAIL reset_model cyc=%0d got=%h exp=%h", k, act_v(), exp_v);
            end
            advance();
        end
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        advance();
    endtask

    task automatic test_fetch();
        mem[16] = 32'h13;
        ref_mem[16] = 32'h13;
        drive(1'b0, 1'b1, 10'h010, 1'b0, 1'b0, '0, '0);
        n_checks++;
        if (i_gnt !== 1'b1 || mem_addr !== 10'h010) begin
            n_err++;
            $display("FAIL fetch_gnt got=%b/%h exp=1/010", i_gnt, mem_addr);
        end
        advance();
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        n_checks++;
        if (i_rvalid !== 1'b1 || d_rvalid !== 1'b0 || rdata !== 32'h13) begin
            n_err++;
            $display("FAIL fetch_rvalid got=%b%b/%h exp=10/00000013", i_rvalid, d_rvalid, rdata);
        end
        n_checks++;
        if (act_v() !== exp_v) begin
            n_err++;
            $display("FAIL fetch_model got=%h exp=%h", act_v(), exp_v);
        end
        advance();
    endtask

    task automatic test_store_load();
        int we_pulses = 0;
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 10'h3FF, 32'hDEADBEEF);
        we_pulses += int'(mem_we);
        n_checks++;
        if (act_v() !== exp_v) begin
            n_err++;
            $display("FAIL store_model got=%h exp=%h", act_v(), exp_v);
        end
        advance();
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 10'h3FF, '0);
        we_pulses += int'(mem_we);
        n_checks++;
        if (d_rvalid !== 1'b0 || d_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL store_no_rvalid got=%b%b exp=01", d_rvalid, d_gnt);
        end
        advance();
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        we_pulses += int'(mem_we);
        n_checks++;
        if (d_rvalid !== 1'b1 || rdata !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL load_data got=%b/%h exp=1/deadbeef", d_rvalid, rdata);
        end
        n_checks++;
        if (we_pulses != 1) begin
            n_err++;
            $display("FAIL we_pulses got=%0d exp=1", we_pulses);
        end
        advance();
    endtask

    task automatic test_priority();
        for (int k = 0; k < 10; k++) begin
            logic ei;
`ifdef MEM_ARB_STARVE_EN
            ei = (k % 4 == 3);
`else
            ei = 1'b0;
`endif
            drive(1'b0, 1'b1, AW'(k * 7), 1'b1, 1'b0, AW'(k * 3), '0);
            n_checks++;
            if ({i_gnt, d_gnt} !== {ei, ~ei}) begin
                n_err++;
                $display("FAIL priority cyc=%0d got=%b%b exp=%b%b", k, i_gnt, d_gnt, ei, ~ei);
            end
            n_checks++;
            if (act_v() !== exp_v) begin
                n_err++;
                $display("FAIL priority_model cyc=%0d got=%h exp=%h", k, act_v(), exp_v);
            end
            advance();
        end
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        advance();
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b1, 10'h005, 1'b0, 1'b0, '0, '0);
        advance();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b1, 10'h005, 1'b1, 1'b0, 10'h006, '0);
            n_checks++;
            if ({i_rvalid, i_gnt, d_gnt, mem_en} !== {k == 0, 3'b000}) begin
                n_err++;
                $display("FAIL reset_mid cyc=%0d got=%b exp=%b", k,
                         {i_rvalid, i_gnt, d_gnt, mem_en}, {k == 0, 3'b000});
            end
            advance();
        end
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        n_checks++;
        if (act_v() !== exp_v) begin
            n_err++;
            $display("FAIL reset_mid_after got=%h exp=%h", act_v(), exp_v);
        end
        advance();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 15) == 0, 1'($urandom), AW'($urandom), 1'($urandom),
                  1'($urandom), AW'($urandom_range(0, 15)), $urandom);
            n_checks++;
            if (act_v() !== exp_v) begin
                n_err++;
                $display("FAIL random cyc=%0d got=%h exp=%h", k, act_v(), exp_v);
            end
            advance();
        end
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) begin
            mem[a] = $urandom;
            ref_mem[a] = mem[a];
        end
        @(posedge clk);
        #1;
        test_reset();
        test_fetch();
        test_store_load();
        test_priority();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width (1024-word unified memory).
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter MAX_WAIT, default 3, max consecutive cycles a pending fetch may lose arbitration.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 i_req  input  1  instruction-fetch read request, held until i_gnt.
REQ-007 i_addr  input  ADDR_W  fetch word address, stable while i_req high.
REQ-008 i_gnt  output  1  fetch accepted this cycle.
REQ-009 i_rvalid  output  1  fetch read data valid on rdata.
REQ-010 d_req  input  1  load/store request, held until d_gnt.
REQ-011 d_we  input  1  1 = store, 0 = load.
REQ-012 d_addr  input  ADDR_W  load/store word address.
REQ-013 d_wdata  input  DATA_W  store data.
REQ-014 d_gnt  output  1  load/store accepted this cycle.
REQ-015 d_rvalid  output  1  load data valid on rdata.
REQ-016 rdata  output  DATA_W  read data for whichever rvalid is high.
REQ-017 mem_en  output  1  memory access strobe.
REQ-018 mem_we  output  1  memory write enable.
REQ-019 mem_addr  output  ADDR_W  memory word address.
REQ-020 mem_wdata  output  DATA_W  memory write data.
REQ-021 mem_rdata  input  DATA_W  memory read data, valid one cycle after mem_en with mem_we=0.

Function
REQ-022 At most one of i_gnt/d_gnt high per cycle; a gnt is only asserted when its req is high.
REQ-023 Grants are combinational from req, wait counter and reset; mem_en = i_gnt | d_gnt; mem_we = d_gnt & d_we; mem_addr/mem_wdata muxed from the granted side (zero when no grant).
REQ-024 Default priority: when both req high, data side wins.
REQ-025 Wait counter: increments when i_req=1 and i_gnt=0; clears to 0 on i_gnt or i_req=0; saturates at MAX_WAIT.
REQ-026 When counter == MAX_WAIT and i_req=1, fetch wins regardless of d_req.
REQ-027 Response register rsel_q in {NONE, FETCH, LOAD}: FETCH after i_gnt, LOAD after d_gnt with d_we=0, else NONE.
REQ-028 i_rvalid = (rsel_q == FETCH), d_rvalid = (rsel_q == LOAD), exactly one cycle after the grant; rdata = mem_rdata.
REQ-029 Stores produce no rvalid; a store is complete in its grant cycle.
REQ-030 Throughput: one access per cycle; back-to-back grants to either side permitted, no bubble.
REQ-031 A grant in the same cycle as a pending rvalid is legal; response and new access overlap.

Reset
REQ-032 While reset=1: i_gnt=d_gnt=mem_en=mem_we=0, counter=0, rsel_q=NONE next edge, so i_rvalid=d_rvalid=0 the cycle after.
REQ-033 An access granted the cycle before reset asserts still returns its rvalid in the reset cycle; no access is granted during reset.

Configuration
REQ-034 Macro MEM_ARB_STARVE_EN defined: wait counter and REQ-025/026 fetch-promotion compiled in.
REQ-035 Macro undefined: no counter; strict data priority, i_gnt = i_req & ~d_req & ~reset; MAX_WAIT ignored.

Verification
REQ-036 reset=1, i_req=d_req=1 for 3 cycles -> i_gnt=d_gnt=mem_en=0, no rvalid.
REQ-037 i_req only, i_addr=0x010, mem returns 0x00000013 -> i_gnt cycle N, i_rvalid=1 and rdata=0x00000013 cycle N+1.
REQ-038 STARVE_EN, MAX_WAIT=3, both req held -> d_gnt cycles 0-2, i_gnt cycle 3, d_gnt cycle 4, pattern repeats.
REQ-039 Store 0xDEADBEEF to 0x3FF then load 0x3FF -> one mem_we pulse, no d_rvalid for store, d_rvalid with rdata=0xDEADBEEF after load.
REQ-040 Macro undefined, both req held 10 cycles -> d_gnt every cycle, i_gnt never.
REQ-041 reset asserted cycle after i_gnt, held 2 cycles -> i_rvalid once (reset cycle), then 0; no grants until reset deasserts.
